// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO onto a valid/ready stream, framed into PKT_LEN-word
// packets; a 2-entry skid buffer hides the FIFO's one-cycle read latency.
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int PKT_LEN   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 read_enb,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic                 busy
);

  localparam int            PW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

  state_e               state_q, state_d;
  logic [1:0]           occ_q, occ_d, occ_after_pop;
  logic [WIDTH-1:0]     skid_q [2];
  logic [WIDTH-1:0]     skid_d [2];
  logic                 inflight_q, inflight_d;
  logic [PW-1:0]        rd_cnt_q, rd_cnt_d;
  logic [PW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic                 pop, issue_ok, occ_overflow, at_boundary;
  logic [2:0]           committed;

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = skid_q[0];
  assign m_last    = m_valid && (tx_cnt_q == LAST_IDX);
  assign pkt_count = pkt_count_q;
  assign busy      = (state_q != IDLE) || (occ_q != 2'd0);
  assign pop       = m_valid && m_ready;

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    skid_d        = skid_q;
    occ_after_pop = occ_q;
    occ_overflow  = 1'b0;
    rd_cnt_d      = rd_cnt_q;
    tx_cnt_d      = tx_cnt_q;
    pkt_count_d   = pkt_count_q;

    // Words already owned (buffered or in flight) minus the one leaving now
    // must leave room for the word this read would bring in.
    issue_ok  = (state_q == RUN) || ((state_q == STOPPING) && (rd_cnt_q != '0));
    committed = {1'b0, occ_q} + {2'b00, inflight_q};
    read_enb  = issue_ok && !empty && (committed < (3'd2 + {2'b00, pop}));
    inflight_d = read_enb;

    if (read_enb) begin
      rd_cnt_d = (rd_cnt_q == LAST_IDX) ? '0 : rd_cnt_q + 1'b1;
    end

    if (pop) begin
      skid_d[0]     = skid_q[1];
      occ_after_pop = occ_q - 2'd1;
      tx_cnt_d      = (tx_cnt_q == LAST_IDX) ? '0 : tx_cnt_q + 1'b1;
      if (m_last) begin
        pkt_count_d = pkt_count_q + 1'b1;
      end
    end

    occ_d = occ_after_pop;
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        skid_d[0] = fifo_data;
      end else if (occ_after_pop == 2'd1) begin
        skid_d[1] = fifo_data;
      end else begin
        occ_overflow = 1'b1;
      end
      if (!occ_overflow) begin
        occ_d = occ_after_pop + 2'd1;
      end
    end

    // Judged on post-edge values so an m_last pop coinciding with enable
    // falling lands straight in IDLE.
    at_boundary = (rd_cnt_d == '0) && (tx_cnt_d == '0) && (occ_d == 2'd0) && !inflight_d;

    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = at_boundary ? IDLE : STOPPING;
      end
      STOPPING: begin
        if (enable)           state_d = RUN;
        else if (at_boundary) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      occ_q       <= 2'd0;
      // NOTE: the skid entries are reset because m_data is the head entry
      // and must read 0 out of reset; the two words cost almost nothing.
      skid_q      <= '{default: '0};
      inflight_q  <= 1'b0;
      rd_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      skid_q      <= skid_d;
      inflight_q  <= inflight_d;
      rd_cnt_q    <= rd_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      pkt_count_q <= pkt_count_d;
      assert (!occ_overflow);
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a FIFO model feeds the DUT and a
// scoreboard of {last, data} is compared against every stream handshake.
module tb_fifo_stream_reader;

  localparam int WIDTH     = 8;
  localparam int PKT_LEN   = 4;
  localparam int CNT_WIDTH = 2;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 resetn = 1'b0;
  logic                 enable = 1'b0;
  logic                 m_ready = 1'b0;
  logic                 flush = 1'b0;
  logic                 empty;
  logic [WIDTH-1:0]     fifo_data = '0;
  logic                 read_enb;
  logic [WIDTH-1:0]     m_data;
  logic                 m_valid;
  logic                 m_last;
  logic [CNT_WIDTH-1:0] pkt_count;
  logic                 busy;

  fifo_stream_reader #(
    .WIDTH    (WIDTH),
    .PKT_LEN  (PKT_LEN),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .enable   (enable),
    .empty    (empty),
    .fifo_data(fifo_data),
    .read_enb (read_enb),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .pkt_count(pkt_count),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // FIFO model: data_out is registered one cycle after the pop strobe.
  logic [WIDTH-1:0] fifo_mem [256];
  int               wr_ptr = 0;
  int               rd_ptr = 0;

  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clock) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (read_enb && !empty) begin
      fifo_data <= fifo_mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  exp_t                 sb[$];
  int                   pkt_seq[$];
  int                   checks = 0;
  int                   failures = 0;
  int                   cyc = 0;
  int                   idx = 0;
  int                   rd_seen, popped, first_rd, last_rd, first_valid;
  logic [CNT_WIDTH-1:0] exp_pkt = '0;
  logic                 pkt_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    exp_t e;
    fifo_mem[wr_ptr[7:0]] = d;
    wr_ptr++;
    e.last = ((idx % PKT_LEN) == PKT_LEN - 1);
    e.data = d;
    sb.push_back(e);
    idx++;
  endtask

  task automatic clear_test();
    rd_seen     = 0;
    popped      = 0;
    first_rd    = -1;
    last_rd     = -1;
    first_valid = -1;
  endtask

  // Inputs are driven just after a rising edge; outputs are sampled at the
  // following falling edge, before the edge that acts on them.
  task automatic step();
    @(negedge clock);
    cyc++;
    if (pkt_pending) begin
      pkt_pending = 1'b0;
      check("pkt_count", 32'(pkt_count), 32'(exp_pkt));
      pkt_seq.push_back(int'(pkt_count));
    end
    if (read_enb) begin
      rd_seen++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      check("read_while_empty", 32'(empty), 32'd0);
    end
    if (m_valid && sb.size() == 0) begin
      check("spurious_valid", 32'(m_valid), 32'd0);
    end else if (m_valid) begin
      if (first_valid < 0) first_valid = cyc;
      check("m_data", 32'(m_data), 32'(sb[0].data));
      check("m_last", 32'(m_last), 32'(sb[0].last));
      if (m_ready) begin
        if (sb[0].last) begin
          exp_pkt     = exp_pkt + 1'b1;
          pkt_pending = 1'b1;
        end
        void'(sb.pop_front());
        popped++;
      end
    end else begin
      check("m_last_idle", 32'(m_last), 32'd0);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int keep, input int max_cycles);
    int n;
    n = 0;
    while (sb.size() > keep && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'(keep));
  endtask

  initial begin
    int n;
    int rel_cyc;
    int exp_seq [5];

    // Reset held with a runnable FIFO and enable high.
    enable  = 1'b1;
    m_ready = 1'b1;
    clear_test();
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    repeat (3) step();
    check("rst_read_enb", 32'(read_enb), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_no_reads", 32'(rd_seen), 32'd0);

    // Single packet: release mid-cycle, four back-to-back reads, latency 2.
    rel_cyc = cyc;
    #2 resetn = 1'b1;
    drain(0, 30);
    step();
    check("single_reads", 32'(rd_seen), 32'd4);
    check("single_first_read", 32'(first_rd), 32'(rel_cyc + 2));
    check("single_consecutive", 32'(last_rd - first_rd), 32'd3);
    check("single_latency", 32'(first_valid - first_rd), 32'd2);
    check("single_pkt_count", 32'(pkt_count), 32'd1);

    // Backpressure: 8 words, sink stalled for 6 cycles.
    clear_test();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'h50 + 8'(i));
    repeat (6) step();
    check("bp_reads_stalled", 32'(rd_seen), 32'd2);
    check("bp_valid_stalled", 32'(m_valid), 32'd1);
    check("bp_head_held", 32'(m_data), 32'h50);
    m_ready = 1'b1;
    drain(0, 40);
    step();
    check("bp_delivered", 32'(popped), 32'd8);
    check("bp_pkt_count", 32'(pkt_count), 32'd3);

    // Starvation: FIFO runs dry after word 2 of a packet.
    clear_test();
    push_word(8'hA1); push_word(8'hA2);
    repeat (8) step();
    check("starve_popped", 32'(popped), 32'd2);
    check("starve_valid_gap", 32'(m_valid), 32'd0);
    check("starve_busy", 32'(busy), 32'd1);
    push_word(8'hA3); push_word(8'hA4);
    drain(0, 20);
    step();
    check("starve_reads", 32'(rd_seen), 32'd4);
    check("starve_pkt_wrap", 32'(pkt_count), 32'd0);

    // Stop at boundary: enable falls after the second read of a packet.
    clear_test();
    for (int i = 1; i <= 5; i++) push_word(8'hB0 + 8'(i));
    n = 0;
    while (rd_seen < 2 && n < 20) begin
      step();
      n++;
    end
    check("stop_second_read", 32'(rd_seen), 32'd2);
    enable = 1'b0;
    drain(1, 30);
    repeat (3) step();
    check("stop_reads", 32'(rd_seen), 32'd4);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_read_enb", 32'(read_enb), 32'd0);
    check("stop_word5_left", 32'(wr_ptr - rd_ptr), 32'd1);
    check("stop_pkt_count", 32'(pkt_count), 32'd1);
    sb.delete();
    idx   = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Asynchronous reset after the third word of a packet.
    clear_test();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'hC0 + 8'(i));
    n = 0;
    while (popped < 3 && n < 20) begin
      step();
      n++;
    end
    check("arst_third_word", 32'(popped), 32'd3);
    resetn = 1'b0;
    #1;
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_read_enb", 32'(read_enb), 32'd0);
    check("arst_m_last", 32'(m_last), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pkt_count", 32'(pkt_count), 32'd0);
    sb.delete();
    idx         = 0;
    exp_pkt     = '0;
    pkt_pending = 1'b0;
    flush       = 1'b1;
    step();
    flush = 1'b0;
    step();
    resetn = 1'b1;

    // Counter wrap: five packets through a 2-bit packet counter.
    pkt_seq.delete();
    for (int i = 0; i < 5 * PKT_LEN; i++) push_word(8'hD0 + 8'(i));
    drain(0, 80);
    step();
    exp_seq = '{1, 2, 3, 0, 1};
    check("wrap_seq_len", 32'(pkt_seq.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < pkt_seq.size()) check("wrap_seq", 32'(pkt_seq[i]), 32'(exp_seq[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Downstream consumer of the synchronous-reset FIFO (WIDTH 8, DEPTH 16).
- Pops words via read_enb while the FIFO is not empty and presents them on a valid/ready stream, framed into fixed-length packets with m_last.
- A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, so the block sustains 1 word/cycle under backpressure without losing data.
- Stops only at packet boundaries.

Parameters:
- WIDTH, 8: data width; matches the FIFO.
- PKT_LEN, 4: words per packet; must be ≥ 1.
- CNT_WIDTH, 16: width of the completed-packet counter.

Ports:
- clock  input  1  Sole clock; all logic on the rising edge.
- resetn  input  1  Asynchronous active-low reset.
- enable  input  1  Run request; level-sensitive.
- empty  input  1  FIFO empty flag.
- fifo_data  input  WIDTH  FIFO data_out; valid in the cycle after read_enb.
- read_enb  output  1  FIFO pop strobe; combinational from registered state and empty.
- m_data  output  WIDTH  Stream data.
- m_valid  output  1  Stream valid.
- m_ready  input  1  Stream ready from the sink.
- m_last  output  1  High with the PKT_LEN-th word of each packet.
- pkt_count  output  CNT_WIDTH  Completed packets; wraps to 0.
- busy  output  1  High when state ≠ IDLE or the skid buffer is non-empty.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; skid buffer emptied; in-flight flag cleared; rd_cnt and tx_cnt = 0.
  - Outputs: read_enb 0, m_valid 0, m_data 0, m_last 0, pkt_count 0, busy 0.
  - Reset mid-packet discards buffered and in-flight words; no m_last is emitted.
- States:
  - IDLE → RUN when enable = 1.
  - RUN → STOPPING when enable = 0 and (rd_cnt ≠ 0 or tx_cnt ≠ 0).
  - RUN → IDLE when enable = 0 and both counters are 0.
  - STOPPING → IDLE when tx_cnt returns to 0, i.e. the m_last handshake completes and the buffer is empty.
  - STOPPING → RUN if enable returns to 1.
- Read issue: read_enb = issue_ok AND !empty AND (occ + inflight − pop) < 2, where:
  - occ = skid entries (0..2).
  - inflight = read_enb registered from the previous cycle.
  - pop = m_valid & m_ready.
  - issue_ok = (state == RUN) or (state == STOPPING and rd_cnt ≠ 0).
  - read_enb is never asserted while empty = 1.
- rd_cnt: increments on each read_enb and wraps PKT_LEN−1 → 0.
- Capture: when inflight = 1, fifo_data is written into the skid tail at the clock edge. occ never exceeds 2; if it would, that is an assertion failure.
- Output:
  - m_valid = occ ≠ 0; m_data is the head entry.
  - First-word latency is 2 cycles: read_enb in cycle t → m_valid in cycle t+2.
  - Throughput is 1 word/cycle when m_ready = 1 continuously.
- Hold: while m_valid = 1 and m_ready = 0, m_data and m_last are stable.
- m_last: m_last = m_valid and tx_cnt == PKT_LEN−1.
  - On pop, tx_cnt increments, wrapping to 0.
  - If m_last is popped, pkt_count increments the following cycle, wrapping 2^CNT_WIDTH−1 → 0.
- FIFO empty mid-packet: reads pause and m_valid drops when the buffer drains. The packet resumes when data returns; no m_last is inserted early.
- Simultaneous capture and pop in one cycle: occ is unchanged and order is preserved (FIFO order in equals order out).
- Simultaneous enable fall and m_last pop: go to IDLE directly.

Test Plan:
- Reset: hold resetn = 0 with enable = 1 and empty = 0 → read_enb 0, m_valid 0, m_last 0, pkt_count 0, busy 0. Release mid-cycle → no read in that cycle.
- Single packet: FIFO preloaded with 0x11, 0x22, 0x33, 0x44; enable = 1; m_ready = 1.
  - read_enb high for 4 consecutive cycles.
  - m_data 0x11..0x44 starting 2 cycles after the first read_enb; m_last only with 0x44.
  - pkt_count = 1 afterward.
- Backpressure: FIFO holds 8 words; m_ready = 0 for 6 cycles, then 1.
  - At most 2 reads issued while stalled; m_data is stable at the head word.
  - All 8 words delivered in order; m_last on words 4 and 8; pkt_count = 2.
- Starvation: empty toggles after word 2 for 5 cycles.
  - read_enb is never high while empty = 1; m_valid gaps appear.
  - m_last only on word 4.
- Stop at boundary: enable drops after word 2 is read.
  - Block still reads and delivers words 3 and 4 with m_last, then enters IDLE and busy = 0.
  - Word 5 stays in the FIFO.
- Async reset mid-packet and wrap: resetn pulse after word 3 clears outputs immediately.
  - With CNT_WIDTH = 2, 5 packets give pkt_count sequence 1, 2, 3, 0, 1.
